crvga: RTL and testbench



---
 rtl/crvga_pkg.sv | 40 ++++
 rtl/crvga_counter.sv | 48 ++++
 rtl/crvga.sv | 145 ++++++++++++++
 tb/tb_crvga.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/crvga_pkg.sv
// ----------------------------------------------------------------------------
// crvga_pkg -- shared constants for the CRVGA timing generator.
//
// Holds the default 640x480@60 timing (visible / front porch / sync / back
// porch for both axes), the derived line and frame totals, and the bit
// positions used when the three colour bits are handled as one vector.
// Build option CRVGA_CLKDIV2_EN is interpreted in crvga.sv, not here.
// ----------------------------------------------------------------------------
package crvga_pkg;

    // Horizontal timing, in pixel ticks.
    localparam int CRVGA_H_VISIBLE = 640;
    localparam int CRVGA_H_FRONT   = 16;
    localparam int CRVGA_H_SYNC    = 96;
    localparam int CRVGA_H_BACK    = 48;

    // Vertical timing, in lines.
    localparam int CRVGA_V_VISIBLE = 480;
    localparam int CRVGA_V_FRONT   = 10;
    localparam int CRVGA_V_SYNC    = 2;
    localparam int CRVGA_V_BACK    = 33;

    // Sum of the four phases of one axis.
    function automatic int timing_total(input int vis, input int front,
                                        input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int CRVGA_H_TOTAL = timing_total(CRVGA_H_VISIBLE, CRVGA_H_FRONT,
                                                CRVGA_H_SYNC, CRVGA_H_BACK);
    localparam int CRVGA_V_TOTAL = timing_total(CRVGA_V_VISIBLE, CRVGA_V_FRONT,
                                                CRVGA_V_SYNC, CRVGA_V_BACK);

    // Colour vector layout: {R, G, B}.
    localparam int COLOR_W     = 3;
    localparam int COLOR_R_BIT = 2;
    localparam int COLOR_G_BIT = 1;
    localparam int COLOR_B_BIT = 0;

endpackage

// File: rtl/crvga_counter.sv
// ----------------------------------------------------------------------------
// crvga_counter -- modulo-N up counter with enable and synchronous reset.
//
// Parameters: N (modulus), W (register width, must hold N-1).
// Ports:
//   clock    in   clock
//   reset    in   synchronous active-high reset, clears the count
//   en_i     in   advance by one (wrapping N-1 -> 0) on this edge
//   count_o  out  current count, straight from the register
//   wrap_o   out  high when the next enabled edge wraps to 0 (en_i & at N-1)
// ----------------------------------------------------------------------------
module crvga_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_last;

    always_comb begin
        at_last = (count_q == LAST);
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i & at_last;

endmodule

// File: rtl/crvga.sv
// ----------------------------------------------------------------------------
// crvga -- VGA raster timing generator with colour blanking.
//
// A column counter advances once per pixel tick; when it wraps, the row
// counter advances in the same tick. Sync pulses and the visible window are
// decoded combinationally from the registered counters, and the requested
// colour is passed straight through while inside the visible window.
//
// Build option:
//   CRVGA_CLKDIV2_EN  defined   -> pixel tick every second clock (clock is 2x
//                                  the pixel rate); first tick on the second
//                                  edge after reset release.
//                     undefined -> pixel tick every clock.
//
// Ports:
//   clock                      in   sole clock
//   reset                      in   synchronous, active-high
//   iCrvgaR/iCrvgaG/iCrvgaB    in   requested pixel colour
//   oCrvgaR/oCrvgaG/oCrvgaB    out  colour, forced to 0 outside visible area
//   hoz_sync                   out  horizontal sync, active low
//   ver_sync                   out  vertical sync, active low
//   oCurrentCol                out  column counter, zero-extended to 32 bits
//   oCurrentRow                out  row counter, zero-extended to 32 bits
// ----------------------------------------------------------------------------
module crvga
    import crvga_pkg::*;
#(
    parameter int H_VISIBLE = CRVGA_H_VISIBLE,
    parameter int H_FRONT   = CRVGA_H_FRONT,
    parameter int H_SYNC    = CRVGA_H_SYNC,
    parameter int H_BACK    = CRVGA_H_BACK,
    parameter int V_VISIBLE = CRVGA_V_VISIBLE,
    parameter int V_FRONT   = CRVGA_V_FRONT,
    parameter int V_SYNC    = CRVGA_V_SYNC,
    parameter int V_BACK    = CRVGA_V_BACK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iCrvgaR,
    input  logic        iCrvgaG,
    input  logic        iCrvgaB,
    output logic        oCrvgaR,
    output logic        oCrvgaG,
    output logic        oCrvgaB,
    output logic        hoz_sync,
    output logic        ver_sync,
    output logic [31:0] oCurrentCol,
    output logic [31:0] oCurrentRow
);

    localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int CW_H    = $clog2(H_TOTAL);
    localparam int CW_V    = $clog2(V_TOTAL);

    localparam logic [CW_H-1:0] H_VIS_END = CW_H'(H_VISIBLE);
    localparam logic [CW_H-1:0] HS_FIRST  = CW_H'(H_VISIBLE + H_FRONT);
    localparam logic [CW_H-1:0] HS_LAST   = CW_H'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW_V-1:0] V_VIS_END = CW_V'(V_VISIBLE);
    localparam logic [CW_V-1:0] VS_FIRST  = CW_V'(V_VISIBLE + V_FRONT);
    localparam logic [CW_V-1:0] VS_LAST   = CW_V'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic            pix_tick;
    logic [CW_H-1:0] col;
    logic [CW_V-1:0] row;
    logic            h_wrap;
    logic            v_wrap_unused;  // frame-end flag, no consumer at this level
    logic            h_sync_act;
    logic            v_sync_act;
    logic            visible;
    logic [COLOR_W-1:0] rgb_in;
    logic [COLOR_W-1:0] rgb_out;

`ifdef CRVGA_CLKDIV2_EN
    // Phase is 0 straight out of reset, so the first edge after release
    // only flips it and the counters first move on the second edge.
    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = ~phase_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign pix_tick = phase_q;
`else
    assign pix_tick = 1'b1;
`endif

    crvga_counter #(
        .N (H_TOTAL),
        .W (CW_H)
    ) u_col (
        .clock   (clock),
        .reset   (reset),
        .en_i    (pix_tick),
        .count_o (col),
        .wrap_o  (h_wrap)
    );

    // The row moves on the very tick the column wraps, so both wrap together
    // at the bottom-right corner.
    crvga_counter #(
        .N (V_TOTAL),
        .W (CW_V)
    ) u_row (
        .clock   (clock),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (row),
        .wrap_o  (v_wrap_unused)
    );

    always_comb begin
        rgb_in              = '0;
        rgb_in[COLOR_R_BIT] = iCrvgaR;
        rgb_in[COLOR_G_BIT] = iCrvgaG;
        rgb_in[COLOR_B_BIT] = iCrvgaB;
    end

    // Decodes use only registered counters; reset additionally forces the
    // idle levels so the connector is quiet while reset is held.
    always_comb begin
        h_sync_act = (col >= HS_FIRST) && (col <= HS_LAST);
        v_sync_act = (row >= VS_FIRST) && (row <= VS_LAST);
        visible    = (col < H_VIS_END) && (row < V_VIS_END) && !reset;
        hoz_sync   = reset | ~h_sync_act;
        ver_sync   = reset | ~v_sync_act;
        rgb_out    = visible ? rgb_in : '0;
    end

    assign oCrvgaR     = rgb_out[COLOR_R_BIT];
    assign oCrvgaG     = rgb_out[COLOR_G_BIT];
    assign oCrvgaB     = rgb_out[COLOR_B_BIT];
    assign oCurrentCol = 32'(col);
    assign oCurrentRow = 32'(row);

endmodule

// File: tb/tb_crvga.sv
// ----------------------------------------------------------------------------
// tb_crvga -- scoreboard bench for crvga.
//
// The horizontal timing is the default 800-tick line; the vertical timing is
// shortened (12/3/2/5 = 22 lines) so full frames fit in a short run while
// still exercising the sync window, the visible edge and the frame wrap.
// The reference model derives position purely from the number of pixel ticks
// elapsed since reset release. Works with or without CRVGA_CLKDIV2_EN.
// ----------------------------------------------------------------------------
module tb_crvga;

    localparam int HV = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VV = 12;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef CRVGA_CLKDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int W = 69;  // {col[31:0], row[31:0], hs, vs, rgb[2:0]}

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic        iCrvgaR, iCrvgaG, iCrvgaB;
    logic        oCrvgaR, oCrvgaG, oCrvgaB;
    logic        hoz_sync, ver_sync;
    logic [31:0] oCurrentCol, oCurrentRow;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    crvga #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iCrvgaR     (iCrvgaR),
        .iCrvgaG     (iCrvgaG),
        .iCrvgaB     (iCrvgaB),
        .oCrvgaR     (oCrvgaR),
        .oCrvgaG     (oCrvgaG),
        .oCrvgaB     (oCrvgaB),
        .hoz_sync    (hoz_sync),
        .ver_sync    (ver_sync),
        .oCurrentCol (oCurrentCol),
        .oCurrentRow (oCurrentRow)
    );

    // ---------------- reference model ----------------
    int clk_since_rel;
    int m_col;
    int m_row;
    int n_cmp;
    int n_bad;
    int cyc;
    logic [W-1:0] exp_q[$];

    // Position follows from tick count alone: ticks = clocks / DIV.
    task automatic model_edge();
        int ticks;
        int pos;
        @(posedge clock);
        #1;
        cyc++;
        if (reset) clk_since_rel = 0;
        else       clk_since_rel++;
        ticks = clk_since_rel / DIV;
        pos   = ticks % FRAME;
        m_col = pos % HT;
        m_row = pos / HT;
    endtask

    function automatic logic [W-1:0] expect_of(input int c, input int r,
                                               input logic rst,
                                               input logic [2:0] rgb);
        logic hs_e, vs_e, vis;
        logic [2:0] out_e;
        hs_e  = rst || !(c >= HV + HF && c < HV + HF + HS);
        vs_e  = rst || !(r >= VV + VF && r < VV + VF + VS);
        vis   = !rst && c < HV && r < VV;
        out_e = vis ? rgb : 3'b000;
        return {32'(c), 32'(r), hs_e, vs_e, out_e};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [2:0] rgb);
        reset   = rst;
        iCrvgaR = rgb[2];
        iCrvgaG = rgb[1];
        iCrvgaB = rgb[0];
        exp_q.push_back(expect_of(m_col, m_row, rst, rgb));
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("col",      oCurrentCol,                  e[68:37]);
                check("row",      oCurrentRow,                  e[36:5]);
                check("hoz_sync", 32'(hoz_sync),                32'(e[4]));
                check("ver_sync", 32'(ver_sync),                32'(e[3]));
                check("rgb_out",  32'({oCrvgaR, oCrvgaG, oCrvgaB}), 32'(e[2:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit hit;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        clk_since_rel = 0;
        m_col = 0;
        m_row = 0;
        reset   = 1'b1;
        iCrvgaR = 1'b1;
        iCrvgaG = 1'b1;
        iCrvgaB = 1'b1;

        // Reset held three clocks with white requested.
        repeat (3) begin
            model_edge();
            drive(1'b1, 3'b111);
        end

        // One full frame plus a line with constant magenta: covers the
        // visible corners, blanking, both sync windows and the frame wrap.
        repeat ((FRAME + HT) * DIV) begin
            model_edge();
            drive(1'b0, 3'b101);
        end

        // Random colours until (300,8), then a one-clock reset there.
        hit = 1'b0;
        for (int i = 0; i < (FRAME + 4) * DIV; i++) begin
            model_edge();
            if (m_col == 300 && m_row == 8) begin
                hit = 1'b1;
                break;
            end
            drive(1'b0, 3'($urandom_range(0, 7)));
        end
        if (hit) begin
            drive(1'b1, 3'($urandom_range(0, 7)));
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL reach_300_8: got not_reached expected reached (cycle %0d)", cyc);
            drive(1'b0, 3'b000);
        end

        // Counting must resume cleanly after the mid-frame reset.
        repeat (3 * HT * DIV) begin
            model_edge();
            drive(1'b0, 3'($urandom_range(0, 7)));
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
